// File: rtl/bus_pkg.sv
// Shared bus encodings for the core / memory interface.
package bus_pkg;

  // d_width encodings; 2'd3 is illegal
  localparam logic [1:0] W_BYTE = 2'd0;
  localparam logic [1:0] W_HALF = 2'd1;
  localparam logic [1:0] W_WORD = 2'd2;

  // Owner of the access whose response is due next cycle
  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_e;

  // Response tag: rd marks an issued read, tail is the data byte offset
  typedef struct packed {
    logic       rd;
    owner_e     owner;
    logic [1:0] tail;
  } resp_tag_t;

  // MMIO is decoded upstream; these addresses are out of range for the arbiter
  localparam logic [31:0] MMIO_BASE      = 32'h4000_0000;
  localparam logic [31:0] MMIO_DEBUG_OUT = MMIO_BASE + 32'd4;
  localparam logic [31:0] MMIO_TIMER     = MMIO_BASE + 32'd8;

endpackage

// File: rtl/lane_align.sv
// Byte-lane helper: write byte enables and shift, read shift, alignment check.
module lane_align
  import bus_pkg::*;
(
  input  logic [1:0]  width,
  input  logic [1:0]  wr_tail,
  input  logic [31:0] wdata,
  input  logic [1:0]  rd_tail,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata_sh,
  output logic [31:0] rdata_sh,
  output logic        misaligned
);

  // Byte enables per width; illegal width counts as misaligned
  always_comb begin
    be         = 4'b0000;
    misaligned = 1'b0;
    case (width)
      W_BYTE: be = 4'b0001 << wr_tail;
      W_HALF: begin
        be         = 4'b0011 << wr_tail;
        misaligned = (wr_tail == 2'd3);
      end
      W_WORD: begin
        be         = 4'b1111;
        misaligned = (wr_tail != 2'd0);
      end
      default: misaligned = 1'b1;
    endcase
  end

  // Move right-justified write data onto its lanes, and read lanes back down
  always_comb begin
    wdata_sh = wdata << {wr_tail, 3'b000};
    rdata_sh = rdata >> {rd_tail, 3'b000};
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one byte-writable single-port memory between fetch and data ports.
//
// Arbitration is combinational: data wins unless a pending fetch has lost
// STARVE_LIMIT consecutive cycles. A registered response tag steers the
// memory read data to the owning port one cycle after the grant.
module mem_port_arbiter
  import bus_pkg::*;
#(
  parameter int MEM_WORDS    = 4096,
  parameter int STARVE_LIMIT = 4,
  localparam int AW          = $clog2(MEM_WORDS)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          i_req,
  input  logic [31:0]   i_addr,
  output logic          i_gnt,
  output logic          i_rvalid,
  output logic [31:0]   i_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [1:0]    d_width,
  input  logic [31:0]   d_addr,
  input  logic [31:0]   d_wdata,
  output logic          d_gnt,
  output logic          d_rvalid,
  output logic [31:0]   d_rdata,
  output logic          d_err,
  output logic          m_en,
  output logic [3:0]    m_be,
  output logic [AW-1:0] m_addr,
  output logic [31:0]   m_wdata,
  input  logic [31:0]   m_rdata
);

  localparam logic [32:0] BYTE_LIMIT = 33'(MEM_WORDS) << 2;
  localparam logic [3:0]  STARVE_MAX = 4'(STARVE_LIMIT);

  logic [3:0]  starve_q, starve_d;
  resp_tag_t   tag_q, tag_d;
  logic [31:0] i_rdata_q, i_rdata_d;
  logic [31:0] d_rdata_q, d_rdata_d;

  logic        fetch_win;
  logic        d_bad;
  logic        d_ok;
  logic [3:0]  lane_be;
  logic [31:0] lane_wdata;
  logic [31:0] lane_rdata;
  logic        lane_misaligned;
  logic        unused_addr_bits;

  // Fetch ignores its byte offset and wraps modulo the memory depth
  assign unused_addr_bits = ^{i_addr[1:0], i_addr[31:AW+2]};

  lane_align u_lane_align (
    .width      (d_width),
    .wr_tail    (d_addr[1:0]),
    .wdata      (d_wdata),
    .rd_tail    (tag_q.tail),
    .rdata      (m_rdata),
    .be         (lane_be),
    .wdata_sh   (lane_wdata),
    .rdata_sh   (lane_rdata),
    .misaligned (lane_misaligned)
  );

  // Grant selection and request checks; nothing is granted during reset
  always_comb begin
    fetch_win = i_req && (!d_req || (starve_q == STARVE_MAX));
    i_gnt     = !reset && fetch_win;
    d_gnt     = !reset && d_req && !fetch_win;
    d_bad     = lane_misaligned || ({1'b0, d_addr} >= BYTE_LIMIT);
    d_ok      = d_gnt && !d_bad;
    d_err     = d_gnt && d_bad;
  end

  // Memory-side drive; rejected data requests leave the memory idle
  always_comb begin
    m_en    = i_gnt || d_ok;
    m_be    = 4'b0000;
    m_wdata = 32'h0;
    m_addr  = d_addr[AW+1:2];
    if (i_gnt) begin
      m_addr = i_addr[AW+1:2];
    end else if (d_ok && d_we) begin
      m_be    = lane_be;
      m_wdata = lane_wdata;
    end
  end

  // Starvation count: cleared on fetch grant, idle fetch port or reset
  always_comb begin
    starve_d = starve_q;
    if (reset || !i_req || i_gnt) begin
      starve_d = 4'd0;
    end else if (starve_q != 4'hF) begin
      starve_d = starve_q + 4'd1;
    end
  end

  // Response tag for the access issued this cycle; writes and errors carry no read
  always_comb begin
    tag_d       = '0;
    tag_d.rd    = i_gnt || (d_ok && !d_we);
    tag_d.owner = i_gnt ? OWN_I : OWN_D;
    tag_d.tail  = d_addr[1:0];
    if (reset) begin
      tag_d = '0;
    end
  end

  // Response delivery; a pending read is dropped if reset arrives first
  always_comb begin
    i_rvalid  = !reset && tag_q.rd && (tag_q.owner == OWN_I);
    d_rvalid  = !reset && tag_q.rd && (tag_q.owner == OWN_D);
    i_rdata   = i_rvalid ? m_rdata : i_rdata_q;
    d_rdata   = d_rvalid ? lane_rdata : d_rdata_q;
    i_rdata_d = reset ? 32'h0 : i_rdata;
    d_rdata_d = reset ? 32'h0 : d_rdata;
  end

  // State registers
  always_ff @(posedge clock) begin
    starve_q  <= starve_d;
    tag_q     <= tag_d;
    i_rdata_q <= i_rdata_d;
    d_rdata_q <= d_rdata_d;
  end

endmodule
